// File: rtl/ifetch_if.sv
// Handshake bundle between ifetch_ctrl, instruction memory and decode.
// The master modport is the fetch controller's view; the slave modport is the environment's.
interface ifetch_if #(
  parameter int XLEN      = 32,
  parameter int WORD_SIZE = 32
);
  logic                 redirect_valid;
  logic [XLEN-1:0]      redirect_pc;
  logic                 mem_req_valid;
  logic                 mem_req_ready;
  logic [XLEN-1:0]      mem_req_addr;
  logic                 mem_rsp_valid;
  logic [WORD_SIZE-1:0] mem_rsp_data;
  logic                 instr_valid;
  logic                 instr_ready;
  logic [WORD_SIZE-1:0] instr;
  logic [XLEN-1:0]      instr_pc;
  logic [XLEN-1:0]      instr_pcp4;

  modport master (
    input  redirect_valid, redirect_pc, mem_req_ready, mem_rsp_valid, mem_rsp_data, instr_ready,
    output mem_req_valid, mem_req_addr, instr_valid, instr, instr_pc, instr_pcp4
  );

  modport slave (
    output redirect_valid, redirect_pc, mem_req_ready, mem_rsp_valid, mem_rsp_data, instr_ready,
    input  mem_req_valid, mem_req_addr, instr_valid, instr, instr_pc, instr_pcp4
  );
endinterface

// File: rtl/ifetch_ctrl.sv
// Instruction fetch sequencer: one outstanding memory request, small PC-tagged buffer to decode.
// Define IFETCH_PERF_CNT_EN to add the perf_fetched / perf_flushed counters.
module ifetch_ctrl #(
  parameter int              XLEN       = 32,
  parameter int              WORD_SIZE  = 32,
  parameter int              FIFO_DEPTH = 2,
  parameter logic [XLEN-1:0] ENTRY_ADDR = '0
) (
  input  logic        clk,
  input  logic        reset,
  ifetch_if.master    bus
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed
`endif
);
  localparam int              PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0]  DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]  PTR_ONE = (PTR_W+1)'(1);

  typedef enum logic [1:0] {ISSUE, WAIT, DRAIN} state_t;

  state_t               state;
  logic [XLEN-1:0]      fetch_pc;
  logic [PTR_W:0]       wr_ptr;
  logic [PTR_W:0]       rd_ptr;
  logic [PTR_W:0]       count;
  logic [WORD_SIZE-1:0] buf_word [FIFO_DEPTH];
  logic [XLEN-1:0]      buf_pc   [FIFO_DEPTH];
  logic                 req_fire;
  logic                 push;
  logic                 pop;
  logic                 has_entry;
  logic                 has_slot;
  logic [XLEN-1:0]      head_pc;

  assign count     = wr_ptr - rd_ptr;
  assign has_entry = (count != '0);
  // A request is only issued when a slot is free, so the eventual push cannot overflow.
  assign has_slot  = (count < DEPTH_C);

  assign bus.mem_req_valid = !reset && (state == ISSUE) && has_slot && !bus.redirect_valid;
  assign bus.mem_req_addr  = reset ? '0 : fetch_pc;
  assign req_fire          = bus.mem_req_valid && bus.mem_req_ready;
  assign push              = (state == WAIT) && bus.mem_rsp_valid && !bus.redirect_valid;

  assign bus.instr_valid = !reset && has_entry;
  assign pop             = bus.instr_valid && bus.instr_ready && !bus.redirect_valid;
  assign head_pc         = buf_pc[rd_ptr[PTR_W-1:0]];
  assign bus.instr       = bus.instr_valid ? buf_word[rd_ptr[PTR_W-1:0]] : '0;
  assign bus.instr_pc    = bus.instr_valid ? head_pc : '0;
  assign bus.instr_pcp4  = bus.instr_valid ? head_pc + XLEN'(4) : '0;

  // Buffer storage: data only, never reset.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_word[wr_ptr[PTR_W-1:0]] <= bus.mem_rsp_data;
      buf_pc[wr_ptr[PTR_W-1:0]]   <= fetch_pc;
    end
  end

  // Sequencer and buffer pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ISSUE;
      fetch_pc <= ENTRY_ADDR;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      if (bus.redirect_valid) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        fetch_pc <= bus.redirect_pc;
      end else begin
        if (push) begin
          wr_ptr   <= wr_ptr + PTR_ONE;
          fetch_pc <= fetch_pc + XLEN'(4);
        end
        if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      end
      // A redirect never coincides with an ISSUE handshake (the request is masked), and a
      // redirect landing on the drained response itself still retires that response.
      unique case (state)
        ISSUE:   if (req_fire) state <= WAIT;
        WAIT:    if (bus.mem_rsp_valid) state <= ISSUE;
                 else if (bus.redirect_valid) state <= DRAIN;
        DRAIN:   if (bus.mem_rsp_valid) state <= ISSUE;
        default: state <= ISSUE;
      endcase
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  logic discard;

  assign discard = bus.mem_rsp_valid &&
                   ((state == DRAIN) || ((state == WAIT) && bus.redirect_valid));

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      if (push) perf_fetched <= perf_fetched + 32'd1;
      perf_flushed <= perf_flushed
                    + (bus.redirect_valid ? 32'(count) : 32'd0)
                    + (discard ? 32'd1 : 32'd0);
    end
  end
`endif
endmodule

// File: tb/tb_ifetch_ctrl.sv
// Randomized bench for ifetch_ctrl: behavioural memory plus an expected-instruction-queue model.
module tb_ifetch_ctrl;
  localparam int          DEPTH = 2;
  localparam logic [31:0] ENTRY = 32'h0000_0080;

  logic clk = 1'b0;
  logic reset;
  ifetch_if #(.XLEN(32), .WORD_SIZE(32)) bus ();
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;
`endif

  ifetch_ctrl #(.XLEN(32), .WORD_SIZE(32), .FIFO_DEPTH(DEPTH), .ENTRY_ADDR(ENTRY)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef IFETCH_PERF_CNT_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_flushed (perf_flushed)
`endif
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] q[$];
  logic [31:0] popped[$];
  logic [31:0] popped_p4[$];
  logic [31:0] fires[$];
  bit          outst, stale, mem_pend, last_fire;
  int          mem_cnt, cur_lat, n_fires;
  logic [31:0] mem_addr, exp_req, last_addr;
  int unsigned m_fetched, m_flushed;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_0F1E;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    q.delete(); popped.delete(); popped_p4.delete(); fires.delete();
    outst = 0; stale = 0; mem_pend = 0; mem_cnt = 0; n_fires = 0; last_fire = 0;
    exp_req = ENTRY; m_fetched = 0; m_flushed = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.mem_req_ready = 1'b1;
    bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = '0; bus.instr_ready = 1'b1;
    #1;
    check("rst_req_valid", bus.mem_req_valid, 0);
    check("rst_instr_valid", bus.instr_valid, 0);
    check("rst_req_addr", bus.mem_req_addr, 0);
    check("rst_instr", bus.instr, 0);
    check("rst_instr_pc", bus.instr_pc, 0);
    check("rst_instr_pcp4", bus.instr_pcp4, 0);
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic step(input bit ir, input bit rr, input bit rdv, input logic [31:0] rdpc);
    bit rsp, fire, pop;
    rsp = mem_pend && (mem_cnt == 0);
    bus.instr_ready    = ir;
    bus.mem_req_ready  = rr;
    bus.redirect_valid = rdv;
    bus.redirect_pc    = rdpc;
    bus.mem_rsp_valid  = rsp;
    bus.mem_rsp_data   = rsp ? word_of(mem_addr) : $urandom;
    #1;
    check("req_valid", bus.mem_req_valid, (!outst && q.size() < DEPTH && !rdv));
    check("instr_valid", bus.instr_valid, q.size() != 0);
    if (q.size() != 0) begin
      check("instr_pc", bus.instr_pc, q[0]);
      check("instr", bus.instr, word_of(q[0]));
      check("instr_pcp4", bus.instr_pcp4, 32'(q[0] + 32'd4));
    end
    if (bus.mem_req_valid) check("req_addr", bus.mem_req_addr, exp_req);
`ifdef IFETCH_PERF_CNT_EN
    check("perf_fetched", perf_fetched, m_fetched);
    check("perf_flushed", perf_flushed, m_flushed);
`endif
    fire = bus.mem_req_valid && rr;
    pop  = (q.size() != 0) && ir && !rdv;
    last_fire = fire;
    last_addr = bus.mem_req_addr;
    if (pop) begin
      popped.push_back(bus.instr_pc);
      popped_p4.push_back(bus.instr_pcp4);
      void'(q.pop_front());
    end
    if (rdv) begin
      m_flushed += q.size();
      q.delete();
      exp_req = rdpc;
    end
    if (rsp) begin
      mem_pend = 0;
      outst    = 0;
      if (stale || rdv) m_flushed++;
      else begin
        q.push_back(mem_addr);
        m_fetched++;
      end
      stale = 0;
    end else if (rdv && outst) begin
      stale = 1;
    end
    if (fire) begin
      mem_pend = 1; outst = 1; stale = 0;
      mem_addr = bus.mem_req_addr;
      mem_cnt  = cur_lat - 1;
      exp_req  = exp_req + 32'd4;
      n_fires++;
      fires.push_back(bus.mem_req_addr);
    end else if (mem_pend) begin
      mem_cnt--;
    end
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw84;
    reset = 1'b1;
    cur_lat = 1;
    @(negedge clk);
    do_reset();

    // Sequential fetch, 1-cycle memory, decode always ready
    cur_lat = 1;
    for (int i = 0; i < 30 && popped.size() < 3; i++) step(1, 1, 0, '0);
    if (popped.size() < 3) check("t1_timeout", popped.size(), 3);
    else begin
      check("t1_pc0", popped[0], 32'h80);
      check("t1_pc1", popped[1], 32'h84);
      check("t1_pc2", popped[2], 32'h88);
      check("t1_pcp4", popped_p4[0], 32'h84);
    end

    // Decode stalled: buffer fills, requests stop, then drains in order
    do_reset();
    cur_lat = 1;
    for (int i = 0; i < 10; i++) step(0, 1, 0, '0);
    check("t2_reqs", n_fires, 2);
    for (int i = 0; i < 10 && popped.size() < 2; i++) step(1, 1, 0, '0);
    if (popped.size() < 2) check("t2_timeout", popped.size(), 2);
    else begin
      check("t2_pc0", popped[0], 32'h80);
      check("t2_pc1", popped[1], 32'h84);
    end

    // Redirect while waiting on a 3-cycle memory
    do_reset();
    cur_lat = 3;
    for (int i = 0; i < 30 && !(last_fire && last_addr == 32'h84); i++) step(0, 1, 0, '0);
    if (!(last_fire && last_addr == 32'h84)) check("t3_timeout_req", 0, 1);
    popped.delete();
    step(1, 1, 1, 32'h200);
    for (int i = 0; i < 40 && popped.size() < 1; i++) step(1, 1, 0, '0);
    if (popped.size() < 1) check("t3_timeout", 0, 1);
    else begin
      check("t3_first_pc", popped[0], 32'h200);
      saw84 = 0;
      foreach (popped[k]) if (popped[k] == 32'h84) saw84 = 1;
      check("t3_no_84", saw84, 0);
`ifdef IFETCH_PERF_CNT_EN
      check("t6_flushed", perf_flushed, 2);
      check("t6_fetched", perf_fetched, 2);
`endif
    end

    // Redirect in the same cycle as the response
    do_reset();
    cur_lat = 2;
    for (int i = 0; i < 10 && !last_fire; i++) step(1, 1, 0, '0);
    for (int i = 0; i < 10 && !(mem_pend && mem_cnt == 0); i++) step(1, 1, 0, '0);
    if (!(mem_pend && mem_cnt == 0)) check("t4_timeout", 0, 1);
    step(1, 1, 1, 32'h200);
    step(1, 1, 0, '0);
    check("t4_req_next", last_fire, 1);
    check("t4_req_addr", last_addr, 32'h200);
    check("t4_none_out", popped.size(), 0);

    // Memory back-pressure, then PC wrap
    do_reset();
    cur_lat = 2;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, '0);
      check("t5_addr_hold", last_addr, ENTRY);
    end
    for (int i = 0; i < 3; i++) step(0, 1, 0, '0);
    check("t5_one_req", n_fires, 1);
    fires.delete();
    step(0, 1, 1, 32'hFFFF_FFFC);
    for (int i = 0; i < 20 && fires.size() < 2; i++) step(1, 1, 0, '0);
    if (fires.size() < 2) check("t5_timeout", fires.size(), 2);
    else begin
      check("t5_wrap_a", fires[0], 32'hFFFF_FFFC);
      check("t5_wrap_b", fires[1], 32'h0000_0000);
    end

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit ir, rr, rdv;
      if (i == 1500) do_reset();
      cur_lat = int'($urandom_range(1, 4));
      ir  = ($urandom % 4) != 0;
      rr  = ($urandom % 3) != 0;
      rdv = (($urandom % 20) == 0) && !(mem_pend && mem_cnt == 0 && stale);
      step(ir, rr, rdv, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
